// File: rtl/mem_access_ctrl_if.sv
// Request/response channel between the CPU load/store stage and mem_access_ctrl.
// master = load/store stage, slave = the controller.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store initiator for a word-wide RAM port.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
module mem_access_ctrl (
  input  logic                clk_100M,
  input  logic                rst,
  mem_access_ctrl_if.slave    bus,
  output logic [31:0]         mem_addr,
  output logic                mem_wr_en,
  output logic                mem_clk_en,
  output logic [31:0]         mem_w_data,
  input  logic [31:0]         mem_r_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]  state_reg;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic [1:0]  lane_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rd_word_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic        req_bad;
  logic [31:0] load_ext;
  logic [31:0] merged_word;

  assign req_bad = (bus.req_size == 2'b11) ||
                   (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                   (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);

  // Lane selection and extension straight off the RAM read data during RD.
  always_comb begin
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    sel_byte = mem_r_data[{lane_reg, 3'b000} +: 8];
    sel_half = mem_r_data[{lane_reg[1], 4'b0000} +: 16];
    load_ext = mem_r_data;
    if (size_reg == SZ_BYTE)
      load_ext = {{24{sel_byte[7] & ~uns_reg}}, sel_byte};
    else if (size_reg == SZ_HALF)
      load_ext = {{16{sel_half[15] & ~uns_reg}}, sel_half};
  end

  always_comb begin
    merged_word = rd_word_reg;
    if (size_reg == SZ_BYTE)
      merged_word[{lane_reg, 3'b000} +: 8] = wdata_reg[7:0];
    else if (size_reg == SZ_HALF)
      merged_word[{lane_reg[1], 4'b0000} +: 16] = wdata_reg[15:0];
    else
      merged_word = wdata_reg;
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      uns_reg       <= 1'b0;
      lane_reg      <= 2'b00;
      wdata_reg     <= 32'd0;
      rd_word_reg   <= 32'd0;
      mem_addr_reg  <= 32'd0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            we_reg        <= bus.req_we;
            size_reg      <= bus.req_size;
            uns_reg       <= bus.req_unsigned;
            lane_reg      <= bus.req_addr[1:0];
            wdata_reg     <= bus.req_wdata;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
            if (req_bad) begin
              rsp_err_reg <= 1'b1;
              state_reg   <= RESP;
            end else begin
              mem_addr_reg <= {bus.req_addr[31:2], 2'b00};
              if (bus.req_we && bus.req_size == SZ_WORD)
                state_reg <= WR;
              else
                state_reg <= RD;
            end
          end
        end
        RD: begin
          rd_word_reg <= mem_r_data;
          if (we_reg) begin
            state_reg <= WR;
          end else begin
            rsp_rdata_reg <= load_ext;
            state_reg     <= RESP;
          end
        end
        WR: state_reg <= RESP;
        RESP: begin
          if (bus.rsp_ready)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write strobe is gated by reset so a reset landing in WR never commits.
  assign mem_wr_en  = (state_reg == WR) && !rst;
  assign mem_clk_en = mem_wr_en;
  assign mem_w_data = (state_reg == WR) ? merged_word : 32'd0;
  assign mem_addr   = mem_addr_reg;

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed test of mem_access_ctrl against a small behavioural RAM.
module tb_mem_access_ctrl;

  logic        clk_100M = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic        mem_clk_en;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  logic [31:0] ram [0:15];
  int          wr_cnt = 0;
  int          clken_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  int n_vec = 0;
  int n_err = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .bus        (bus.slave),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_clk_en (mem_clk_en),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
  );

  always #5 clk_100M = ~clk_100M;

  assign mem_r_data = ram[mem_addr[5:2]];

  always @(posedge clk_100M) begin
    if (mem_clk_en) clken_cnt <= clken_cnt + 1;
    if (mem_wr_en) begin
      ram[mem_addr[5:2]] <= mem_w_data;
      wr_cnt             <= wr_cnt + 1;
      last_wr_addr       <= mem_addr;
      last_wr_data       <= mem_w_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: present request in IDLE, count cycles to rsp_valid,
  // optionally hold rsp_ready low for `hold` cycles, then complete handshake.
  task automatic issue(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, output int lat, output logic [31:0] rdata,
                       output logic err);
    logic [31:0] first_rdata;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk_100M);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk_100M);
      #1;
      lat++;
    end
    rdata       = bus.rsp_rdata;
    err         = bus.rsp_err;
    first_rdata = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_100M);
      #1;
      chk({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      chk({tag, "_hold_rdata"}, bus.rsp_rdata, first_rdata);
      chk({tag, "_hold_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk_100M);
    #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
    $display("op %-10s we=%0b size=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b",
             tag, we, size, addr, wdata, lat, rdata, err);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          wr0;

    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;
    repeat (3) @(posedge clk_100M);
    #1;
    rst = 1'b0;

    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_w_data, 32'd0);
    chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);

    // Preload word 0x10 via a word store
    wr0 = wr_cnt;
    issue("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 0, lat, rd, er);
    chk("st_w10_lat", lat, 2);
    chk("st_w10_rdata", rd, 32'd0);
    chk("st_w10_wrs", wr_cnt - wr0, 1);
    chk("st_w10_ram", ram[4], 32'h8899AABB);

    issue("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, lat, rd, er);
    chk("ld_w10_lat", lat, 2);
    chk("ld_w10_rdata", rd, 32'h8899AABB);
    chk("ld_w10_err", {31'd0, er}, 32'd0);

    issue("ld_b12_s", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 0, lat, rd, er);
    chk("ld_b12_s_rdata", rd, 32'hFFFFFF99);
    issue("ld_b12_u", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 0, lat, rd, er);
    chk("ld_b12_u_rdata", rd, 32'h00000099);

    wr0 = wr_cnt;
    issue("st_b13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005A, 0, lat, rd, er);
    chk("st_b13_lat", lat, 3);
    chk("st_b13_wrs", wr_cnt - wr0, 1);
    chk("st_b13_waddr", last_wr_addr, 32'h10);
    chk("st_b13_wdata", last_wr_data, 32'h5A99AABB);
    chk("st_b13_rdata", rd, 32'd0);
    issue("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, lat, rd, er);
    chk("ld_w10b_rdata", rd, 32'h5A99AABB);

    issue("st_h10", 1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF1234, 0, lat, rd, er);
    chk("st_h10_lat", lat, 3);
    chk("st_h10_ram", ram[4], 32'h5A991234);
    issue("ld_h10_s", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0, lat, rd, er);
    chk("ld_h10_s_rdata", rd, 32'h00001234);
    issue("ld_h12_s", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, lat, rd, er);
    chk("ld_h12_s_rdata", rd, 32'h00005A99);

    issue("st_w14", 1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, 0, lat, rd, er);
    chk("st_w14_waddr", last_wr_addr, 32'h14);
    issue("ld_h16_s", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 0, lat, rd, er);
    chk("ld_h16_s_rdata", rd, 32'hFFFFCAFE);
    issue("ld_h14_u", 1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 0, lat, rd, er);
    chk("ld_h14_u_rdata", rd, 32'h0000F00D);
    issue("ld_b15_s", 1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 0, lat, rd, er);
    chk("ld_b15_s_rdata", rd, 32'hFFFFFFF0);

    // Error cases: no RAM activity, response one cycle after acceptance
    wr0 = wr_cnt;
    issue("err_h11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000BEEF, 0, lat, rd, er);
    chk("err_h11_lat", lat, 1);
    chk("err_h11_err", {31'd0, er}, 32'd1);
    chk("err_h11_rdata", rd, 32'd0);
    issue("err_w12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0, lat, rd, er);
    chk("err_w12_lat", lat, 1);
    chk("err_w12_err", {31'd0, er}, 32'd1);
    issue("err_sz3", 1'b1, 2'b11, 1'b0, 32'h10, 32'h11111111, 0, lat, rd, er);
    chk("err_sz3_err", {31'd0, er}, 32'd1);
    chk("err_sz3_rdata", rd, 32'd0);
    chk("err_wrs", wr_cnt - wr0, 0);
    chk("err_ram", ram[4], 32'h5A991234);

    // Back-pressure
    issue("bp_ld", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 5, lat, rd, er);
    chk("bp_ld_rdata", rd, 32'hCAFEF00D);

    // Reset during the WR cycle of a byte store
    wr0 = wr_cnt;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_wdata    = 32'h000000EE;
    @(posedge clk_100M);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk_100M);
    #1;
    rst = 1'b1;
    @(posedge clk_100M);
    #1;
    rst = 1'b0;
    chk("rstwr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rstwr_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstwr_wrs", wr_cnt - wr0, 0);
    chk("rstwr_ram", ram[4], 32'h5A991234);
    @(posedge clk_100M);
    #1;
    chk("rstwr_rsp_valid2", {31'd0, bus.rsp_valid}, 32'd0);
    $display("op rst_in_wr  byte store to 10 aborted, ram[10]=%h", ram[4]);

    issue("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, lat, rd, er);
    chk("ld_w10c_rdata", rd, 32'h5A991234);
    chk("clk_en_tracks_wr", clken_cnt, wr_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
